// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory engine among instruction fetch, LSB load and LSB store.
// Optional grant/stall statistics outputs are compiled in when MEM_ARB_STAT_EN is defined.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [31:0] HCI_ADDR     = 32'h0003_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        jump_wrong_flag,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_type,
   input  logic [1:0]  ls_width,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_val,
   input  logic [31:0] ls_rob_id,
   output logic        ls_gnt,
   output logic        ld_done,
   output logic [31:0] ld_val,
   output logic [31:0] ld_rob_id,
   output logic        st_done,
   output logic        eng_req,
   output logic        eng_type,
   output logic [1:0]  eng_width,
   output logic [31:0] eng_addr,
   output logic [31:0] eng_val,
   input  logic        eng_done,
   input  logic [31:0] eng_rdata
`ifdef MEM_ARB_STAT_EN
   ,
   output logic [31:0] stat_if_gnt,
   output logic [31:0] stat_ls_gnt,
   output logic [31:0] stat_io_stall
`endif
);

   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BUSY_IF = 3'd1,
      BUSY_LD = 3'd2,
      BUSY_ST = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [SW-1:0] starve_r, starve_s;
   logic [31:0]   rob_r, rob_s;

   logic          eng_req_s, eng_type_s;
   logic [1:0]    eng_width_s;
   logic [31:0]   eng_addr_s, eng_val_s;
   logic          if_gnt_s, ls_gnt_s, if_done_s, ld_done_s, st_done_s;
   logic [31:0]   if_data_s, ld_val_s, ld_rob_id_s;

   logic          hci_blk_s, st_elig_s, ld_elig_s, if_elig_s, starve_full_s;
   logic          pick_if_s, pick_st_s, pick_ld_s;
   logic [1:0]    ls_width_s;

   // Loads return the engine word zero-extended to the requested width.
   function automatic logic [31:0] zext_load(input logic [1:0] w, input logic [31:0] d);
      logic [31:0] r;
      case (w)
         2'd0:    r = d & 32'h0000_00FF;
         2'd1:    r = d & 32'h0000_FFFF;
         default: r = d;
      endcase
      return r;
   endfunction

   assign hci_blk_s     = io_buffer_full & (ls_addr >= HCI_ADDR);
   assign st_elig_s     = ls_req & ls_type & ~hci_blk_s;
   assign ld_elig_s     = ls_req & ~ls_type & ~jump_wrong_flag;
   assign if_elig_s     = if_req & ~jump_wrong_flag;
   assign starve_full_s = (starve_r == STARVE_MAX);
   assign ls_width_s    = (ls_width == 2'd2) ? 2'd3 : ls_width;

   // Winner selection for an IDLE decision: starved IF first, then store > load > IF.
   always_comb begin
      pick_if_s = 1'b0;
      pick_st_s = 1'b0;
      pick_ld_s = 1'b0;
      if (starve_full_s && if_elig_s) begin
         pick_if_s = 1'b1;
      end else if (st_elig_s) begin
         pick_st_s = 1'b1;
      end else if (ld_elig_s) begin
         pick_ld_s = 1'b1;
      end else if (if_elig_s) begin
         pick_if_s = 1'b1;
      end else begin
         pick_if_s = 1'b0;
      end
   end

   // Next-state, starvation counter and next registered output values.
   always_comb begin
      state_s     = state_r;
      starve_s    = starve_r;
      rob_s       = rob_r;
      eng_req_s   = eng_req;
      eng_type_s  = eng_type;
      eng_width_s = eng_width;
      eng_addr_s  = eng_addr;
      eng_val_s   = eng_val;
      if_data_s   = if_data;
      ld_val_s    = ld_val;
      ld_rob_id_s = ld_rob_id;
      if_gnt_s    = 1'b0;
      ls_gnt_s    = 1'b0;
      if_done_s   = 1'b0;
      ld_done_s   = 1'b0;
      st_done_s   = 1'b0;
      if (rdy) begin
         case (state_r)
            IDLE: begin
               if (pick_if_s) begin
                  state_s     = BUSY_IF;
                  if_gnt_s    = 1'b1;
                  eng_req_s   = 1'b1;
                  eng_type_s  = 1'b0;
                  eng_width_s = 2'd3;
                  eng_addr_s  = if_addr;
                  eng_val_s   = 32'd0;
               end else if (pick_st_s) begin
                  state_s     = BUSY_ST;
                  ls_gnt_s    = 1'b1;
                  eng_req_s   = 1'b1;
                  eng_type_s  = 1'b1;
                  eng_width_s = ls_width_s;
                  eng_addr_s  = ls_addr;
                  eng_val_s   = ls_val;
                  rob_s       = ls_rob_id;
               end else if (pick_ld_s) begin
                  state_s     = BUSY_LD;
                  ls_gnt_s    = 1'b1;
                  eng_req_s   = 1'b1;
                  eng_type_s  = 1'b0;
                  eng_width_s = ls_width_s;
                  eng_addr_s  = ls_addr;
                  eng_val_s   = 32'd0;
                  rob_s       = ls_rob_id;
               end else begin
                  state_s = IDLE;
               end
               if (jump_wrong_flag || pick_if_s || !if_req) begin
                  starve_s = '0;
               end else if ((pick_st_s || pick_ld_s) && !starve_full_s) begin
                  starve_s = starve_r + STARVE_ONE;
               end else begin
                  starve_s = starve_r;
               end
            end
            BUSY_IF, BUSY_LD: begin
               // A flushed fetch/load still owns the engine until it finishes, but reports nothing.
               if (jump_wrong_flag) begin
                  starve_s = '0;
                  if (eng_done) begin
                     state_s   = IDLE;
                     eng_req_s = 1'b0;
                  end else begin
                     state_s = DRAIN;
                  end
               end else if (eng_done) begin
                  state_s   = IDLE;
                  eng_req_s = 1'b0;
                  if (state_r == BUSY_IF) begin
                     if_done_s = 1'b1;
                     if_data_s = eng_rdata;
                  end else begin
                     ld_done_s   = 1'b1;
                     ld_val_s    = zext_load(eng_width, eng_rdata);
                     ld_rob_id_s = rob_r;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            BUSY_ST: begin
               if (jump_wrong_flag) begin
                  starve_s = '0;
               end else begin
                  starve_s = starve_r;
               end
               if (eng_done) begin
                  state_s   = IDLE;
                  eng_req_s = 1'b0;
                  st_done_s = 1'b1;
               end else begin
                  state_s = BUSY_ST;
               end
            end
            DRAIN: begin
               if (jump_wrong_flag) begin
                  starve_s = '0;
               end else begin
                  starve_s = starve_r;
               end
               if (eng_done) begin
                  state_s   = IDLE;
                  eng_req_s = 1'b0;
               end else begin
                  state_s = DRAIN;
               end
            end
            default: begin
               state_s   = IDLE;
               eng_req_s = 1'b0;
               starve_s  = '0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         starve_r  <= '0;
         rob_r     <= 32'd0;
         eng_req   <= 1'b0;
         eng_type  <= 1'b0;
         eng_width <= 2'd0;
         eng_addr  <= 32'd0;
         eng_val   <= 32'd0;
         if_gnt    <= 1'b0;
         ls_gnt    <= 1'b0;
         if_done   <= 1'b0;
         ld_done   <= 1'b0;
         st_done   <= 1'b0;
         if_data   <= 32'd0;
         ld_val    <= 32'd0;
         ld_rob_id <= 32'd0;
      end else begin
         state_r   <= state_s;
         starve_r  <= starve_s;
         rob_r     <= rob_s;
         eng_req   <= eng_req_s;
         eng_type  <= eng_type_s;
         eng_width <= eng_width_s;
         eng_addr  <= eng_addr_s;
         eng_val   <= eng_val_s;
         if_gnt    <= if_gnt_s;
         ls_gnt    <= ls_gnt_s;
         if_done   <= if_done_s;
         ld_done   <= ld_done_s;
         st_done   <= st_done_s;
         if_data   <= if_data_s;
         ld_val    <= ld_val_s;
         ld_rob_id <= ld_rob_id_s;
      end
   end

`ifdef MEM_ARB_STAT_EN
   // Grant and HCI-stall statistics, wrapping, frozen while paused.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_if_gnt   <= 32'd0;
         stat_ls_gnt   <= 32'd0;
         stat_io_stall <= 32'd0;
      end else if (rdy) begin
         stat_if_gnt   <= stat_if_gnt + {31'd0, if_gnt_s};
         stat_ls_gnt   <= stat_ls_gnt + {31'd0, ls_gnt_s};
         stat_io_stall <= stat_io_stall +
                          {31'd0, (state_r == IDLE) & ls_req & ls_type & hci_blk_s};
      end else begin
         stat_if_gnt   <= stat_if_gnt;
         stat_ls_gnt   <= stat_ls_gnt;
         stat_io_stall <= stat_io_stall;
      end
   end
`endif

endmodule
